// File: rtl/fjs_pkg.sv
// rtl/fjs_pkg.sv - fork/join scheduler shared types and join-policy encodings
package fjs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_JOIN = 2'b10
  } state_e;

  localparam logic [1:0] JOIN_ALL  = 2'b00;
  localparam logic [1:0] JOIN_ANY  = 2'b01;
  localparam logic [1:0] JOIN_NONE = 2'b10;

  // The unused encoding 11 behaves as JOIN_ALL.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? JOIN_ALL : m;
  endfunction

endpackage

// File: rtl/fjs_rr_arbiter.sv
// rtl/fjs_rr_arbiter.sv - round-robin picker: first request at or after ptr wins
module fjs_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fork_join_sched.sv
// rtl/fork_join_sched.sv - launches a group of delayed threads that write a shared
// result register, joining under ALL/ANY/NONE policy with disable and kill tracking
module fork_join_sched
  import fjs_pkg::*;
#(
  parameter int NTHREAD = 4,
  parameter int WIDTH   = 4,
  parameter int DLYW    = 4,
  localparam int PW     = (NTHREAD > 1) ? $clog2(NTHREAD) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [NTHREAD-1:0]       thread_en,
  input  logic [NTHREAD*DLYW-1:0]  thread_dly,
  input  logic [NTHREAD*WIDTH-1:0] thread_off,
  input  logic                     disable_req,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic [PW-1:0]            winner,
  output logic                     done,
  output logic                     busy,
  output logic [NTHREAD-1:0]       killed
);

  state_e                          state_q, state_d;
  logic [1:0]                      mode_q, mode_d;
  logic [WIDTH-1:0]                in_q, in_d, out_q, out_d;
  logic [NTHREAD-1:0][DLYW-1:0]    cnt_q, cnt_d;
  logic [NTHREAD-1:0][WIDTH-1:0]   off_q, off_d;
  logic [NTHREAD-1:0]              pend_q, pend_d, killed_q, killed_d;
  logic [PW-1:0]                   ptr_q, ptr_d, winner_q, winner_d;
  logic                            out_valid_q, out_valid_d, done_q, done_d;
  logic                            done_sent_q, done_sent_d;
  logic [NTHREAD-1:0]              ready, req, grant;
  logic                            gnt_valid;
  logic [PW-1:0]                   win_idx;

  always_comb begin
    ready = '0;
    for (int i = 0; i < NTHREAD; i++) begin
      ready[i] = pend_q[i] && (cnt_q[i] == '0);
    end
  end

  assign req = (state_q == ST_RUN) ? ready : '0;

  fjs_rr_arbiter #(.N(NTHREAD), .PW(PW)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt       (grant),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NTHREAD; i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    in_d        = in_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    pend_d      = pend_q;
    killed_d    = killed_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    done_sent_d = done_sent_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (pend_q == '0)) begin
          in_d        = in;
          mode_d      = norm_mode(mode);
          cnt_d       = thread_dly;
          off_d       = thread_off;
          pend_d      = thread_en;
          killed_d    = '0;
          ptr_d       = '0;
          done_sent_d = 1'b0;
          state_d     = (thread_en == '0) ? ST_JOIN : ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NTHREAD; i++) begin
          if (pend_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - DLYW'(1);
        end
        // Disable wins over any write that would land this same edge.
        if (disable_req) begin
          killed_d = killed_q | pend_q;
          pend_d   = '0;
          state_d  = ST_JOIN;
        end else begin
          if ((mode_q == JOIN_NONE) && !done_sent_q) begin
            done_d      = 1'b1;
            done_sent_d = 1'b1;
          end
          if (gnt_valid) begin
            out_d       = in_q + off_q[win_idx];
            out_valid_d = 1'b1;
            winner_d    = win_idx;
            ptr_d       = (int'(win_idx) == NTHREAD - 1) ? '0 : win_idx + PW'(1);
            pend_d      = pend_q & ~grant;
          end
          if ((mode_q == JOIN_ANY) && gnt_valid) begin
            killed_d = killed_q | (pend_q & ~grant);
            pend_d   = '0;
            state_d  = ST_JOIN;
          end else if (pend_d == '0) begin
            state_d = (mode_q == JOIN_NONE) ? ST_IDLE : ST_JOIN;
          end
        end
      end
      ST_JOIN: begin
        done_d      = !done_sent_q;
        done_sent_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= JOIN_ALL;
      in_q        <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      off_q       <= '0;
      pend_q      <= '0;
      killed_q    <= '0;
      ptr_q       <= '0;
      winner_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      done_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      in_q        <= in_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      pend_q      <= pend_d;
      killed_q    <= killed_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      done_sent_q <= done_sent_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign winner    = winner_q;
  assign done      = done_q;
  assign busy      = |pend_q;
  assign killed    = killed_q;

endmodule

// File: tb/tb_fork_join_sched.sv
// tb/tb_fork_join_sched.sv - directed self-checking bench for fork_join_sched
module tb_fork_join_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in;
  logic        start;
  logic [1:0]  mode;
  logic [3:0]  thread_en;
  logic [15:0] thread_dly;
  logic [15:0] thread_off;
  logic        disable_req;
  logic [3:0]  out;
  logic        out_valid;
  logic [1:0]  winner;
  logic        done;
  logic        busy;
  logic [3:0]  killed;

  int n_checks = 0;
  int n_pass   = 0;

  fork_join_sched #(.NTHREAD(4), .WIDTH(4), .DLYW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .start       (start),
    .mode        (mode),
    .thread_en   (thread_en),
    .thread_dly  (thread_dly),
    .thread_off  (thread_off),
    .disable_req (disable_req),
    .out         (out),
    .out_valid   (out_valid),
    .winner      (winner),
    .done        (done),
    .busy        (busy),
    .killed      (killed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a group for one edge (E0); returns 1 time unit after E0.
  task automatic launch(input logic [3:0] i, input logic [1:0] m, input logic [3:0] en,
                        input logic [15:0] dly, input logic [15:0] off);
    in = i; mode = m; thread_en = en; thread_dly = dly; thread_off = off;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in = '0; mode = '0; thread_en = '0;
    thread_dly = '0; thread_off = '0; disable_req = 1'b0;
    #12;
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_winner", winner, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_killed", killed, 0);
    rst = 1'b0;
    tick();

    // JOIN_ALL, two threads with delays 0 and 5
    launch(4'd3, 2'b00, 4'b0011, 16'h0050, 16'h00A0);
    tick();
    chk("all_e1_out", out, 3);
    chk("all_e1_valid", out_valid, 1);
    chk("all_e1_winner", winner, 0);
    for (int e = 2; e <= 5; e++) begin
      tick();
      chk("all_gap_valid", out_valid, 0);
    end
    tick();
    chk("all_e6_out", out, 13);
    chk("all_e6_valid", out_valid, 1);
    chk("all_e6_winner", winner, 1);
    chk("all_e6_done", done, 0);
    tick();
    chk("all_e7_done", done, 1);
    tick();
    chk("all_e8_done", done, 0);
    chk("all_e8_busy", busy, 0);

    // JOIN_ANY, threads 1 and 2 both ready at E6
    launch(4'd3, 2'b01, 4'b0110, 16'h0550, 16'h0DA0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("any_gap_valid", out_valid, 0);
    end
    tick();
    chk("any_e6_out", out, 13);
    chk("any_e6_valid", out_valid, 1);
    chk("any_e6_winner", winner, 1);
    chk("any_e6_killed", killed, 4'b0100);
    tick();
    chk("any_e7_done", done, 1);
    chk("any_e7_valid", out_valid, 0);
    chk("any_e7_busy", busy, 0);

    // JOIN_NONE, done right after start while the thread keeps running
    launch(4'd3, 2'b10, 4'b0001, 16'h0002, 16'h000B);
    tick();
    chk("none_e1_done", done, 1);
    chk("none_e1_busy", busy, 1);
    tick();
    chk("none_e2_done", done, 0);
    chk("none_e2_valid", out_valid, 0);
    tick();
    chk("none_e3_out", out, 14);
    chk("none_e3_valid", out_valid, 1);
    chk("none_e3_busy", busy, 0);
    tick();
    chk("none_e4_done", done, 0);

    // disable_req at E3 kills the pending thread
    launch(4'd1, 2'b00, 4'b0001, 16'h0005, 16'h0004);
    tick();
    tick();
    disable_req = 1'b1;
    tick();
    disable_req = 1'b0;
    chk("dis_e3_killed", killed, 4'b0001);
    chk("dis_e3_valid", out_valid, 0);
    chk("dis_e3_busy", busy, 0);
    tick();
    chk("dis_e4_done", done, 1);
    for (int e = 5; e <= 8; e++) begin
      tick();
      chk("dis_after_valid", out_valid, 0);
      chk("dis_after_done", done, 0);
    end

    // result wraps modulo 16
    launch(4'd15, 2'b00, 4'b0001, 16'h0000, 16'h0003);
    tick();
    chk("wrap_out", out, 2);
    chk("wrap_valid", out_valid, 1);
    chk("wrap_killed_clr", killed, 0);
    tick();
    chk("wrap_done", done, 1);

    // empty group: done next cycle, no write
    launch(4'd7, 2'b00, 4'b0000, 16'h0000, 16'h1111);
    tick();
    chk("empty_done", done, 1);
    chk("empty_valid", out_valid, 0);
    tick();

    // four simultaneously ready threads served round-robin from thread 0
    launch(4'd0, 2'b11, 4'b1111, 16'h0000, 16'h4321);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("rr_winner", winner, e - 1);
      chk("rr_out", out, e);
      chk("rr_valid", out_valid, 1);
    end
    tick();
    chk("rr_done", done, 1);
    tick();

    // a second start while busy is ignored
    launch(4'd0, 2'b10, 4'b0001, 16'h0003, 16'h0005);
    tick();
    chk("ign_e1_done", done, 1);
    in = 4'd9; thread_dly = 16'h0000; thread_off = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_e2_valid", out_valid, 0);
    tick();
    chk("ign_e3_valid", out_valid, 0);
    tick();
    chk("ign_e4_out", out, 5);
    chk("ign_e4_valid", out_valid, 1);
    tick();
    chk("ign_e5_valid", out_valid, 0);

    // asynchronous reset mid-RUN
    launch(4'd1, 2'b00, 4'b0001, 16'h0005, 16'h0007);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_out", out, 0);
    chk("arst_busy", busy, 0);
    #3 rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("arst_after_valid", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fork_join_sched.md
FORK_JOIN_SCHED -- requirements
Module: fork_join_sched

Interface
REQ-001 SHALL have parameter NTHREAD, default 4, number of schedulable threads.
REQ-002 SHALL have parameter WIDTH, default 4, operand/result width.
REQ-003 SHALL have parameter DLYW, default 4, per-thread delay counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in  input  WIDTH  operand, latched at launch.
REQ-008 start  input  1  launch a fork group; only sampled in IDLE.
REQ-009 mode  input  2  join policy: 00 JOIN_ALL, 01 JOIN_ANY, 10 JOIN_NONE, 11 treated as JOIN_ALL.
REQ-010 thread_en  input  NTHREAD  threads included in the group.
REQ-011 thread_dly  input  NTHREAD*DLYW  per-thread delay in cycles.
REQ-012 thread_off  input  NTHREAD*WIDTH  per-thread offset added to in.
REQ-013 disable_req  input  1  kill all pending threads.
REQ-014 out  output  WIDTH  shared result register.
REQ-015 out_valid  output  1  one-cycle pulse when out is written.
REQ-016 winner  output  clog2(NTHREAD)  thread that wrote out last.
REQ-017 done  output  1  one-cycle join-completion pulse.
REQ-018 busy  output  1  high while any thread is pending.
REQ-019 killed  output  NTHREAD  mask of threads disabled in the current group.

Function
REQ-020 SHALL implement states IDLE, RUN, JOIN; IDLE->RUN on start, RUN->JOIN on join condition or disable, JOIN->IDLE after one cycle, or RUN->IDLE when no threads remain pending.
REQ-021 On start in IDLE, SHALL latch in, thread_en, offsets, and delays; clear killed; reset the round-robin pointer to 0.
REQ-022 A thread with delay d SHALL become ready at the edge d+1 after the start edge; d=0 makes it ready on the first RUN edge.
REQ-023 At most one ready thread SHALL write per cycle, chosen round-robin from the pointer; the pointer then moves to winner+1.
REQ-024 Losing ready threads SHALL hold ready and contend on the next cycle.
REQ-025 A write SHALL set out = latched in + offset modulo 2^WIDTH, pulse out_valid, set winner, and retire the thread.
REQ-026 JOIN_ALL: done SHALL pulse the cycle after the last enabled thread retires.
REQ-027 JOIN_ANY: on the first write, all other pending threads SHALL be killed; done SHALL pulse the next cycle.
REQ-028 JOIN_NONE: done SHALL pulse the cycle after start; threads continue running; busy stays high until all retire.
REQ-029 disable_req in RUN SHALL kill all pending threads, suppress any write that cycle (disable beats write), and pulse done next cycle unless done has already pulsed.
REQ-030 start with thread_en=0 SHALL pulse done next cycle with no writes.
REQ-031 start while busy or in RUN/JOIN SHALL be ignored.
REQ-032 Killed threads SHALL set their killed bit and never write.

Reset
REQ-033 rst SHALL immediately force out=0, out_valid=0, winner=0, done=0, busy=0, killed=0, all counters and pending bits to 0, pointer to 0, and state to IDLE.
REQ-034 A reset during RUN SHALL abandon all threads with no further out_valid.

Structure
REQ-035 Package fjs_pkg SHALL hold the state enum and the mode constants JOIN_ALL, JOIN_ANY, and JOIN_NONE.
REQ-036 Round-robin selection SHALL live in sub-module fjs_rr_arbiter (request mask and pointer in; grant one-hot and valid out).

Verification
REQ-037 With in=3, JOIN_ALL, en=0011, dly0=0/off0=0, dly1=5/off1=10 -> out=3 at E1, out=13 at E6, done at E7.
REQ-038 With in=3, JOIN_ANY, en=0110, dly1=dly2=5, off1=10, off2=13 -> thread1 wins at E6 with out=13, killed=0100, done at E7.
REQ-039 With in=3, JOIN_NONE, en=0001, dly0=2, off0=-5 (0xB) -> done at E1, busy=1, out=14 at E3, then busy=0.
REQ-040 With JOIN_ALL, dly0=5, disable_req at E3 -> no out_valid, killed=0001, done at E4, then IDLE.
REQ-041 With in=15, off=3, dly=0 -> out=2 at E1 (wrap).
REQ-042 rst asserted mid-RUN -> out=0 and busy=0 immediately, with no out_valid afterwards.
